// File: rtl/ci_master.sv
// ---------------------------------------------------------------------------
// ci_master
//
// Bridges a valid/ready command/response stream to a multi-cycle custom-
// instruction slave. One command is in flight at a time:
//   IDLE  -> accept a command and latch its operands for the slave
//   ISSUE -> one-cycle start pulse to the slave (clock enable on)
//   WAIT  -> hold the slave enabled until it signals done
//   RESP  -> present the captured result until the consumer takes it
//
// Optional feature (macro CI_TIMEOUT_EN):
//   When defined, WAIT is bounded to TIMEOUT_CYCLES cycles. If done never
//   arrives, the operation is aborted with rsp_data = 0 and rsp_err = 1.
//   A done in the last allowed cycle still completes normally.
//   When undefined, WAIT lasts until done and rsp_err is tied low.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_a, cmd_b, cmd_n    operand words and instruction selector
//   rsp_valid/rsp_ready    response handshake
//   rsp_data, rsp_err      captured slave result; timeout abort flag
//   dataa, datab, n        operands/selector held for the slave
//   start, clk_en          slave start pulse and clock enable
//   result, done           slave result and completion strobe
//   busy                   high whenever an operation is in progress
// ---------------------------------------------------------------------------
module ci_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [7:0]  cmd_n,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] dataa,
  output logic [31:0] datab,
  output logic [7:0]  n,
  output logic        start,
  output logic        clk_en,
  input  logic [31:0] result,
  input  logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // A zero-cycle wait limit would make the timeout unreachable.
  if (TIMEOUT_CYCLES == 0) begin : g_param_chk
    $error("ci_master: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic [31:0] dataa_q, dataa_d;
  logic [31:0] datab_q, datab_d;
  logic [7:0]  n_q, n_d;
  logic [31:0] rsp_data_q, rsp_data_d;

`ifdef CI_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  // Next-state and datapath capture for the command/response sequencer.
  always_comb begin
    state_d    = state_q;
    dataa_d    = dataa_q;
    datab_d    = datab_q;
    n_d        = n_q;
    rsp_data_d = rsp_data_q;
`ifdef CI_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // cmd_ready is high throughout IDLE outside reset, and reset
        // overrides every register, so cmd_valid alone qualifies here.
        if (cmd_valid) begin
          dataa_d = cmd_a;
          datab_d = cmd_b;
          n_d     = cmd_n;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
`ifdef CI_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          // done takes priority over a timeout expiring in the same cycle.
          rsp_data_d = result;
`ifdef CI_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = ST_RESP;
`ifdef CI_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_LAST) begin
          rsp_data_d = 32'h0000_0000;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + CNT_W'(1);
          state_d    = ST_WAIT;
`else
        end else begin
          state_d    = ST_WAIT;
`endif
        end
      end
      ST_RESP: begin
        // Always return through IDLE so a fresh command waits a cycle.
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dataa_q    <= 32'h0000_0000;
      datab_q    <= 32'h0000_0000;
      n_q        <= 8'h00;
      rsp_data_q <= 32'h0000_0000;
`ifdef CI_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dataa_q    <= dataa_d;
      datab_q    <= datab_d;
      n_q        <= n_d;
      rsp_data_q <= rsp_data_d;
`ifdef CI_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  // Control outputs decode straight from the state register; cmd_ready is
  // additionally gated by rst so nothing is accepted while reset is held.
  assign cmd_ready = (state_q == ST_IDLE) & ~rst;
  assign start     = (state_q == ST_ISSUE);
  assign clk_en    = (state_q == ST_ISSUE) | (state_q == ST_WAIT);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);

  assign dataa     = dataa_q;
  assign datab     = datab_q;
  assign n         = n_q;
  assign rsp_data  = rsp_data_q;
`ifdef CI_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ci_master.sv
// ---------------------------------------------------------------------------
// tb_ci_master
//
// Randomised scoreboard bench for ci_master. A driver offers commands, a
// slave model answers each start pulse after a chosen delay, and a monitor
// compares every response (data, error flag, arrival cycle) against an
// expectation computed when the slave saw the start pulse:
//   response appears (delay + 1) cycles after start with the slave result,
//   or, with CI_TIMEOUT_EN and delay > T, (T + 1) cycles after start with
//   data 0 and the error flag set.
// The monitor also tracks protocol rules: operands equal the last accepted
// command, start exactly one cycle after acceptance, clk_en/busy only while
// an operation is outstanding, stable responses under backpressure, and an
// idle cycle after every consumed response.
// ---------------------------------------------------------------------------
module tb_ci_master;

  localparam int T = 16;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [7:0]  cmd_n;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [7:0]  n;
  logic        start;
  logic        clk_en;
  logic [31:0] result;
  logic        done;
  logic        busy;

  ci_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_n     (cmd_n),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .dataa     (dataa),
    .datab     (datab),
    .n         (n),
    .start     (start),
    .clk_en    (clk_en),
    .result    (result),
    .done      (done),
    .busy      (busy)
  );

  typedef struct {
    int          d;
    logic [31:0] res;
  } job_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    longint      cyc;
  } exp_t;

  job_t   job_q[$];
  exp_t   exp_q[$];
  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  bit     abort_next = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Slave model: answers each start after the job's delay, and toggles done
  // randomly whenever no operation is waiting on it.
  initial begin
    job_t   j;
    exp_t   e;
    longint s;
    done   = 1'b0;
    result = 32'h0;
    forever begin
      @(negedge clk);
      if (start && !rst) begin
        s = cyc;
        chk("job_available", job_q.size() > 0, 1'b1);
        if (job_q.size() > 0) j = job_q.pop_front();
        else begin j.d = 1; j.res = 32'h0; end
        e.data = j.res;
        e.err  = 1'b0;
        e.cyc  = s + j.d + 1;
`ifdef CI_TIMEOUT_EN
        if (j.d > T) begin
          e.data = 32'h0;
          e.err  = 1'b1;
          e.cyc  = s + T + 1;
        end
`endif
        if (!abort_next) exp_q.push_back(e);
        for (int i = 1; i <= j.d; i++) begin
          @(posedge clk);
          #1;
          done   = (i == j.d);
          result = (i == j.d) ? j.res : $urandom();
        end
      end else begin
        @(posedge clk);
        #1;
        done   = ($urandom_range(0, 3) == 0);
        result = $urandom();
      end
    end
  end

  // Consumer: every fourth response is held off for at least ten cycles.
  initial begin
    int nresp = 0;
    int age = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        nresp++;
        age = 0;
      end else if (rsp_valid) begin
        age++;
      end
      @(posedge clk);
      #1;
      if (rsp_valid && (nresp % 4 == 0) && age < 10) rsp_ready = 1'b0;
      else rsp_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [31:0] cur_a = 32'h0, cur_b = 32'h0, held_data = 32'h0;
    logic [7:0]  cur_n = 8'h0;
    logic        held_err = 1'b0;
    bit          in_op = 0, acc_pending = 0, prev_valid = 0, hs_prev = 0, prev_rst = 0;
    longint      acc_cyc = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_clk_en", clk_en, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_operands", {dataa, datab, n}, 72'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        cur_a = 32'h0; cur_b = 32'h0; cur_n = 8'h0;
        in_op = 0; acc_pending = 0; prev_valid = 0; hs_prev = 0; prev_rst = 1;
      end else begin
        if (prev_rst) chk("cmd_ready_after_rst", cmd_ready, 1'b1);
        prev_rst = 0;
        chk("dataa_stable", dataa, cur_a);
        chk("datab_stable", datab, cur_b);
        chk("n_stable", n, cur_n);
        if (start) begin
          chk("start_latency", acc_pending ? (cyc - acc_cyc) : -1, 1);
          acc_pending = 0;
          in_op = 1;
        end
        if (rsp_valid) begin
          chk("no_accept_in_resp", cmd_ready, 1'b0);
          chk("no_start_in_resp", start, 1'b0);
          if (!prev_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL rsp_unexpected: got rsp_valid with data 0x%0h, expected none (cycle %0d)", rsp_data, cyc);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_data", rsp_data, e.data);
              chk("rsp_err", rsp_err, e.err);
              chk("rsp_latency", cyc, e.cyc);
            end
            held_data = rsp_data;
            held_err  = rsp_err;
            in_op = 0;
          end else begin
            chk("rsp_data_held", rsp_data, held_data);
            chk("rsp_err_held", rsp_err, held_err);
          end
        end
        if (hs_prev) chk("idle_after_rsp", {rsp_valid, cmd_ready}, 2'b01);
        chk("clk_en", clk_en, in_op);
        chk("busy", busy, in_op || rsp_valid);
        hs_prev    = rsp_valid && rsp_ready;
        prev_valid = rsp_valid && !rsp_ready;
        if (cmd_valid && cmd_ready) begin
          acc_pending = 1;
          acc_cyc = cyc;
          cur_a = cmd_a; cur_b = cmd_b; cur_n = cmd_n;
        end
      end
    end
  end

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] nn,
                      input int d, input logic [31:0] res);
    job_t j;
    bit   got;
    int   k;
    j.d = d;
    j.res = res;
    job_q.push_back(j);
    cmd_a = a;
    cmd_b = b;
    cmd_n = nn;
    cmd_valid = 1'b1;
    got = 0;
    k = 0;
    while (!got && k < 300) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
      k++;
    end
    chk("cmd_accepted", got, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a = $urandom();
    cmd_b = $urandom();
    cmd_n = 8'($urandom());
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || rsp_valid) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("drain", exp_q.size(), 0);
    idle(2);
  endtask

  // Driver.
  initial begin
    int k;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = 32'h0;
    cmd_b = 32'h0;
    cmd_n = 8'h0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Basic operation; first response is also held off by the consumer.
    send(32'h4300_0000, 32'h4000_0000, 8'h01, 4, 32'h4380_0000);
    // Back-to-back: cmd_valid stays high across both commands.
    send($urandom(), $urandom(), 8'($urandom()), 3, $urandom());
    send($urandom(), $urandom(), 8'($urandom()), 2, $urandom());
`ifdef CI_TIMEOUT_EN
    send($urandom(), $urandom(), 8'($urandom()), T + 1, $urandom());
    send($urandom(), $urandom(), 8'($urandom()), T, $urandom());
`else
    send($urandom(), $urandom(), 8'($urandom()), 30, $urandom());
`endif
    for (int i = 0; i < 24; i++) begin
      send($urandom(), $urandom(), 8'($urandom()), $urandom_range(1, 8), $urandom());
      idle($urandom_range(0, 2));
    end
    drain();

    // Reset in the middle of WAIT discards the operation.
    abort_next = 1'b1;
    send($urandom(), $urandom(), 8'($urandom()), 12, $urandom());
    k = 0;
    while (!start && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("abort_start_seen", start, 1'b1);
    idle(3);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_start", start, 1'b0);
    chk("async_rst_clk_en", clk_en, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_rsp_valid", rsp_valid, 1'b0);
    chk("async_rst_cmd_ready", cmd_ready, 1'b0);
    chk("async_rst_dataa", dataa, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    abort_next = 1'b0;
    idle(15);

    send(32'h3F80_0000, 32'h4040_0000, 8'h07, 5, 32'h4080_0000);
    send($urandom(), $urandom(), 8'($urandom()), $urandom_range(1, 8), $urandom());
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ci_master.md
CI_MASTER -- requirements
Module: ci_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the WAIT-state cycle limit (only used when CI_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have ports cmd_a / cmd_b  input  32  operand words (IEEE-754 single).
REQ-007 SHALL have port cmd_n  input  8  custom-instruction selector.
REQ-008 SHALL have port rsp_valid  output  1  response available.
REQ-009 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-010 SHALL have port rsp_data  output  32  captured slave result.
REQ-011 SHALL have port rsp_err  output  1  response is a timeout abort.
REQ-012 SHALL have ports dataa / datab  output  32  operands to the custom-instruction slave.
REQ-013 SHALL have port n  output  8  selector to the slave.
REQ-014 SHALL have ports start / clk_en  output  1 each  slave start pulse and clock enable.
REQ-015 SHALL have ports result  input  32 and done  input  1  slave result and completion.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, SHALL latch cmd_a/cmd_b/cmd_n into dataa/datab/n and go to ISSUE.
REQ-019 ISSUE: start=1 for exactly one cycle, then WAIT; cmd_ready=0 in every state except IDLE.
REQ-020 clk_en SHALL be 1 in ISSUE and WAIT, 0 otherwise.
REQ-021 dataa/datab/n SHALL stay stable from ISSUE until the next command is accepted.
REQ-022 WAIT: on done=1 SHALL capture result into rsp_data, set rsp_err=0, go to RESP; done is ignored outside WAIT.
REQ-023 RESP: rsp_valid=1, rsp_data/rsp_err held stable until rsp_ready=1; then IDLE next cycle.
REQ-024 Latency: command accepted at edge k -> start high cycle k+1 -> with done at cycle k+1+d (d>=1) rsp_valid high from cycle k+2+d.
REQ-025 A new command SHALL NOT be accepted in the cycle the response is consumed (one IDLE cycle minimum between operations).

Reset
REQ-026 On rst=1, SHALL immediately enter IDLE with start=0, clk_en=0, rsp_valid=0, rsp_err=0, busy=0, cmd_ready=0 while rst high, dataa=datab=rsp_data=0, n=0, timeout counter 0.
REQ-027 Reset mid-operation (ISSUE/WAIT/RESP) SHALL discard the operation with no response; cmd_ready=1 the first cycle after rst deasserts.

Configuration
REQ-028 Macro CI_TIMEOUT_EN defined: a counter SHALL clear on WAIT entry, increment each WAIT cycle; on reaching TIMEOUT_CYCLES without done, SHALL go to RESP with rsp_data=0, rsp_err=1.
REQ-029 With CI_TIMEOUT_EN defined, done=1 in the terminal-count cycle SHALL win (normal response, rsp_err=0).
REQ-030 CI_TIMEOUT_EN undefined: no counter, rsp_err tied 0, WAIT held indefinitely until done.

Verification
REQ-031 Basic op: cmd_a=0x43000000, cmd_b=0x40000000, cmd_n=0x01; slave model returns done with result=0x43800000 four cycles after start -> one start pulse, rsp_valid=1 with rsp_data=0x43800000, rsp_err=0, per REQ-024 timing.
REQ-032 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, no second start.
REQ-033 Back-to-back: cmd_valid held high with two commands -> second accepted only after first response consumed plus one IDLE cycle; dataa stable throughout each WAIT.
REQ-034 Timeout (CI_TIMEOUT_EN, TIMEOUT_CYCLES=16): done never asserted -> rsp_valid after 16 WAIT cycles with rsp_data=0, rsp_err=1; repeat with done on cycle 16 -> rsp_err=0.
REQ-035 Reset mid-WAIT: rst pulsed 1 cycle during WAIT -> all outputs at reset values immediately, no rsp_valid, late done ignored, next command runs normally.
